// File: rtl/pause_flow_ctrl_if.sv
// ----------------------------------------------------------------------------
// pause_flow_ctrl_if
// Pause-frame request channel between the flow-control requester and the
// transmit MAC.
//   req  : pause request, held by the requester until acknowledged
//   val  : pause quanta (non-zero = XOFF, zero = XON)
//   addr : destination address carried with the request
//   ack  : single-cycle acceptance pulse from the MAC
// Modports: master = requester side, slave = MAC side.
// ----------------------------------------------------------------------------
interface pause_flow_ctrl_if;
    logic        req;
    logic [15:0] val;
    logic [47:0] addr;
    logic        ack;

    modport master (output req, output val, output addr, input ack);
    modport slave  (input req, input val, input addr, output ack);
endinterface

// File: rtl/pause_flow_ctrl.sv
// ----------------------------------------------------------------------------
// pause_flow_ctrl
// IEEE 802.3x flow-control requester. Watches the receive FIFO fill level
// against high/low watermarks and asks the MAC to send XOFF (PAUSE_QUANTA)
// when congested and XON (zero quanta) once drained. XOFF is re-sent every
// REFRESH_CYCLES while congestion persists.
// Ports:
//   tx_clk     : clock
//   rstn       : asynchronous active-low reset
//   enable     : flow control enabled
//   fifo_level : receive FIFO occupancy (FIFO_AW+1 bits, tx_clk domain)
//   tx_pause   : pause request channel (req/val/addr out, ack in)
//   paused     : link partner is considered paused
//   xoff_cnt   : XOFF requests accepted by the MAC, saturating
// ----------------------------------------------------------------------------
module pause_flow_ctrl #(
    parameter int          FIFO_AW        = 9,
    parameter int          HI_WM          = 448,
    parameter int          LO_WM          = 128,
    parameter logic [15:0] PAUSE_QUANTA   = 16'h5A0F,
    parameter logic [47:0] PAUSE_DA       = 48'h0180C2000001,
    parameter int          REFRESH_CYCLES = 65536
) (
    input  logic                  tx_clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [FIFO_AW:0]      fifo_level,
    pause_flow_ctrl_if.master     tx_pause,
    output logic                  paused,
    output logic [15:0]           xoff_cnt
);

    localparam int LVL_W = FIFO_AW + 1;
    localparam int TMR_W = $clog2(REFRESH_CYCLES) + 1;

    // Watermarks at full level width so a completely full FIFO compares right.
    localparam logic [LVL_W-1:0] HI_LVL   = LVL_W'(HI_WM);
    localparam logic [LVL_W-1:0] LO_LVL   = LVL_W'(LO_WM);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XOFF_REQ = 2'd1,
        PAUSED   = 2'd2,
        XON_REQ  = 2'd3
    } state_t;

    state_t             state, nxt_state;
    logic [TMR_W-1:0]   timer, nxt_timer;
    logic               req_q, nxt_req;
    logic [15:0]        val_q, nxt_val;
    logic [47:0]        addr_q, nxt_addr;
    logic               nxt_paused;
    logic [15:0]        nxt_xoff_cnt;

    logic congested, drained;
    assign congested = fifo_level >= HI_LVL;
    assign drained   = fifo_level <= LO_LVL;

    always_ff @(posedge tx_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            timer    <= '0;
            req_q    <= 1'b0;
            val_q    <= '0;
            addr_q   <= '0;
            paused   <= 1'b0;
            xoff_cnt <= '0;
        end else begin
            state    <= nxt_state;
            timer    <= nxt_timer;
            req_q    <= nxt_req;
            val_q    <= nxt_val;
            addr_q   <= nxt_addr;
            paused   <= nxt_paused;
            xoff_cnt <= nxt_xoff_cnt;
        end
    end

    always_comb begin
        nxt_state    = state;
        nxt_timer    = timer;
        nxt_req      = req_q;
        nxt_val      = val_q;
        nxt_addr     = addr_q;
        nxt_paused   = paused;
        nxt_xoff_cnt = xoff_cnt;

        case (state)
            IDLE: begin
                if (enable && congested) begin
                    nxt_state = XOFF_REQ;
                    nxt_req   = 1'b1;
                    nxt_val   = PAUSE_QUANTA;
                    nxt_addr  = PAUSE_DA;
                end
            end

            // Once raised, the XOFF is never withdrawn; level/enable changes
            // are acted on only after the MAC accepts it.
            XOFF_REQ: begin
                if (tx_pause.ack) begin
                    nxt_state  = PAUSED;
                    nxt_req    = 1'b0;
                    nxt_val    = '0;
                    nxt_addr   = '0;
                    nxt_paused = 1'b1;
                    nxt_timer  = TMR_LOAD;
                    if (xoff_cnt != 16'hFFFF)
                        nxt_xoff_cnt = xoff_cnt + 16'd1;
                end
            end

            // Timer is loaded with REFRESH_CYCLES-1 and the refresh fires on the
            // edge that sees zero, giving exactly REFRESH_CYCLES cycles.
            PAUSED: begin
                if (timer != '0)
                    nxt_timer = timer - 1'b1;
                if (drained || !enable) begin
                    nxt_state = XON_REQ;
                    nxt_req   = 1'b1;
                    nxt_val   = '0;
                    nxt_addr  = PAUSE_DA;
                end else if (timer == '0) begin
                    nxt_state = XOFF_REQ;
                    nxt_req   = 1'b1;
                    nxt_val   = PAUSE_QUANTA;
                    nxt_addr  = PAUSE_DA;
                end
            end

            XON_REQ: begin
                if (tx_pause.ack) begin
                    nxt_state  = IDLE;
                    nxt_req    = 1'b0;
                    nxt_val    = '0;
                    nxt_addr   = '0;
                    nxt_paused = 1'b0;
                end
            end

            default: begin
                nxt_state = IDLE;
                nxt_req   = 1'b0;
                nxt_val   = '0;
                nxt_addr  = '0;
            end
        endcase
    end

    assign tx_pause.req  = req_q;
    assign tx_pause.val  = val_q;
    assign tx_pause.addr = addr_q;

endmodule

// File: tb/tb_pause_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pause_flow_ctrl
// Directed bench for pause_flow_ctrl with a 16-cycle refresh interval.
// Inputs change on the falling edge, outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_pause_flow_ctrl;

    localparam logic [15:0] QUANTA = 16'h5A0F;
    localparam logic [47:0] DA     = 48'h0180C2000001;

    logic        tx_clk;
    logic        rstn;
    logic        enable;
    logic [9:0]  fifo_level;
    logic        paused;
    logic [15:0] xoff_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pause_flow_ctrl_if pif ();

    pause_flow_ctrl #(
        .FIFO_AW        (9),
        .HI_WM          (448),
        .LO_WM          (128),
        .PAUSE_QUANTA   (QUANTA),
        .PAUSE_DA       (DA),
        .REFRESH_CYCLES (16)
    ) dut (
        .tx_clk     (tx_clk),
        .rstn       (rstn),
        .enable     (enable),
        .fifo_level (fifo_level),
        .tx_pause   (pif),
        .paused     (paused),
        .xoff_cnt   (xoff_cnt)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [15:0] v, input logic [47:0] a);
        chk({tag, ".req"},  64'(pif.req),  64'(r));
        chk({tag, ".val"},  64'(pif.val),  64'(v));
        chk({tag, ".addr"}, 64'(pif.addr), 64'(a));
    endtask

    // Ack high for exactly one rising edge; returns on the falling edge after it.
    task automatic ack_pulse();
        pif.ack = 1'b1;
        @(negedge tx_clk);
        pif.ack = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        enable     = 1'b0;
        fifo_level = '0;
        pif.ack    = 1'b0;
        repeat (3) @(negedge tx_clk);

        // Reset state
        chk_req("reset", 1'b0, 16'h0, 48'h0);
        chk("reset.paused", 64'(paused), 64'd0);
        chk("reset.xoff_cnt", 64'(xoff_cnt), 64'd0);
        rstn = 1'b1;
        @(negedge tx_clk);

        // XOFF at HI_WM, one-cycle latency, held 10 cycles without ack
        enable     = 1'b1;
        fifo_level = 10'd448;
        #1 chk("xoff.pre_edge.req", 64'(pif.req), 64'd0);
        @(negedge tx_clk);
        chk_req("xoff.first", 1'b1, QUANTA, DA);
        for (int i = 0; i < 10; i++) begin
            @(negedge tx_clk);
            chk_req("xoff.hold", 1'b1, QUANTA, DA);
        end
        ack_pulse();
        chk_req("xoff.acked", 1'b0, 16'h0, 48'h0);
        chk("xoff.paused", 64'(paused), 64'd1);
        chk("xoff.cnt1", 64'(xoff_cnt), 64'd1);

        // XON when level falls below LO_WM
        fifo_level = 10'd127;
        @(negedge tx_clk);
        chk_req("xon.first", 1'b1, 16'h0, DA);
        chk("xon.paused_held", 64'(paused), 64'd1);
        ack_pulse();
        chk_req("xon.acked", 1'b0, 16'h0, 48'h0);
        chk("xon.paused", 64'(paused), 64'd0);

        // Hysteresis band from IDLE: no request; stray ack ignored
        fifo_level = 10'd300;
        repeat (3) @(negedge tx_clk);
        ack_pulse();
        repeat (2) @(negedge tx_clk);
        chk("hyst.req", 64'(pif.req), 64'd0);
        chk("hyst.cnt", 64'(xoff_cnt), 64'd1);

        // Refresh: XOFF again exactly 16 cycles after the ack edge
        fifo_level = 10'd448;
        @(negedge tx_clk);
        chk_req("refresh.xoff", 1'b1, QUANTA, DA);
        fifo_level = 10'd400;
        ack_pulse();
        chk("refresh.cnt2_pending", 64'(xoff_cnt), 64'd2);
        for (int k = 1; k <= 16; k++) begin
            @(negedge tx_clk);
            chk($sformatf("refresh.k%0d.req", k), 64'(pif.req), 64'(k == 16));
        end
        chk_req("refresh.second", 1'b1, QUANTA, DA);
        chk("refresh.paused", 64'(paused), 64'd1);
        ack_pulse();
        chk("refresh.cnt3", 64'(xoff_cnt), 64'd3);

        // Level drops during a pending XOFF: XOFF completes, XON follows next cycle
        for (int k = 1; k <= 16; k++) @(negedge tx_clk);
        chk_req("drop.xoff", 1'b1, QUANTA, DA);
        fifo_level = 10'd100;
        repeat (3) @(negedge tx_clk);
        chk_req("drop.xoff_held", 1'b1, QUANTA, DA);
        ack_pulse();
        chk("drop.req_low", 64'(pif.req), 64'd0);
        chk("drop.cnt4", 64'(xoff_cnt), 64'd4);
        @(negedge tx_clk);
        chk_req("drop.xon", 1'b1, 16'h0, DA);
        ack_pulse();
        chk("drop.paused", 64'(paused), 64'd0);

        // Timer expiry coincides with enable falling: XON wins
        fifo_level = 10'd448;
        @(negedge tx_clk);
        chk_req("race.xoff", 1'b1, QUANTA, DA);
        fifo_level = 10'd400;
        ack_pulse();
        for (int k = 1; k <= 15; k++) @(negedge tx_clk);
        chk("race.k15.req", 64'(pif.req), 64'd0);
        enable = 1'b0;
        @(negedge tx_clk);
        chk_req("race.xon", 1'b1, 16'h0, DA);
        ack_pulse();
        chk("race.paused", 64'(paused), 64'd0);
        chk("race.cnt5", 64'(xoff_cnt), 64'd5);

        // enable low blocks XOFF in IDLE, even with a full FIFO
        fifo_level = 10'd512;
        repeat (3) @(negedge tx_clk);
        chk("disabled.req", 64'(pif.req), 64'd0);
        enable = 1'b1;
        @(negedge tx_clk);
        chk_req("full.xoff", 1'b1, QUANTA, DA);

        // Reset mid-handshake while paused with XON pending
        ack_pulse();
        fifo_level = 10'd50;
        @(negedge tx_clk);
        chk_req("rst.xon_pending", 1'b1, 16'h0, DA);
        rstn = 1'b0;
        #1;
        chk_req("rst.async", 1'b0, 16'h0, 48'h0);
        chk("rst.paused", 64'(paused), 64'd0);
        chk("rst.cnt", 64'(xoff_cnt), 64'd0);
        @(negedge tx_clk);
        fifo_level = 10'd300;
        rstn = 1'b1;
        repeat (2) @(negedge tx_clk);
        chk("rst.idle.req", 64'(pif.req), 64'd0);
        fifo_level = 10'd448;
        @(negedge tx_clk);
        chk_req("rst.restart", 1'b1, QUANTA, DA);
        ack_pulse();
        chk("rst.cnt1", 64'(xoff_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
